// File: rtl/pipe_ctrl_unit.sv
// ID-stage control decode registered into the ID/EX boundary, with load-use
// stall, EX-stage branch/jump flush and an optional multi-cycle RV32M hold.
module pipe_ctrl_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int EN_M_EXT    = 1,
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [6:0]            id_opcode_i,
  input  logic [2:0]            id_func3_i,
  input  logic [6:0]            id_func7_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  ex_alu_zero_i,
  input  logic                  ex_alu_lsb_i,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  ex_valid_o,
  output logic [2:0]            ex_imm_src_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_alu_src_o,
  output logic                  ex_reg_write_o,
  output logic [1:0]            ex_wb_src_o,
  output logic                  ex_u_src_o,
  output logic [4:0]            ex_alu_ctrl_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  ex_illegal_o,
  output logic                  ex_mdu_busy_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_U   = 2'b11;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLT  = 5'd5;
  localparam logic [4:0] ALU_SLTU = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9;

  localparam logic [7:0] MUL_LD = 8'(MUL_LATENCY - 1);
  localparam logic [7:0] DIV_LD = 8'(DIV_LATENCY - 1);

  typedef struct packed {
    logic                  valid;
    logic [2:0]            imm_src;
    logic                  mem_read;
    logic                  mem_write;
    logic                  alu_src;
    logic                  reg_write;
    logic [1:0]            wb_src;
    logic                  u_src;
    logic [4:0]            alu_ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic                  illegal;
    logic                  is_branch;
    logic                  is_jump;
    logic [2:0]            func3;
  } ex_ctrl_t;

  ex_ctrl_t   ex_q, ex_d, dec, bub;
  logic [7:0] cnt_q, cnt_d;
  logic       dec_is_m, rs1_used, rs2_used;
  logic       busy, taken, flush, lu;

  function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  always_comb begin
    bub         = '0;
    bub.imm_src = IMM_NONE;
  end

  always_comb begin
    dec       = bub;
    dec.valid = 1'b1;
    dec_is_m  = 1'b0;
    case (id_opcode_i)
      OP_R: begin
        dec.reg_write = 1'b1;
        if (EN_M_EXT != 0 && id_func7_i == 7'b0000001) begin
          dec_is_m     = 1'b1;
          dec.alu_ctrl = {2'b10, id_func3_i};
        end else begin
          dec.alu_ctrl = base_alu(id_func3_i, id_func7_i[5]);
        end
      end
      OP_I: begin
        dec.imm_src = IMM_I;
        dec.alu_src = 1'b1;
        // shift-immediates only accept the two legal func7 patterns
        if (id_func3_i == 3'b001) begin
          dec.reg_write = (id_func7_i == 7'b0000000);
          dec.alu_ctrl  = dec.reg_write ? ALU_SLL : ALU_ADD;
        end else if (id_func3_i == 3'b101) begin
          dec.reg_write = (id_func7_i == 7'b0000000) || (id_func7_i == 7'b0100000);
          dec.alu_ctrl  = dec.reg_write ? base_alu(id_func3_i, id_func7_i[5]) : ALU_ADD;
        end else begin
          dec.reg_write = 1'b1;
          dec.alu_ctrl  = base_alu(id_func3_i, 1'b0);
        end
      end
      OP_LOAD: begin
        dec.imm_src   = IMM_I;
        dec.alu_src   = 1'b1;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_src    = WB_MEM;
      end
      OP_STORE: begin
        dec.imm_src   = IMM_S;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm_src   = IMM_B;
        dec.is_branch = 1'b1;
        dec.func3     = id_func3_i;
        case (id_func3_i[2:1])
          2'b00:   dec.alu_ctrl = ALU_SUB;
          2'b10:   dec.alu_ctrl = ALU_SLT;
          2'b11:   dec.alu_ctrl = ALU_SLTU;
          default: dec.alu_ctrl = ALU_ADD;
        endcase
      end
      OP_JAL: begin
        dec.imm_src   = IMM_J;
        dec.reg_write = 1'b1;
        dec.wb_src    = WB_PC4;
        dec.is_jump   = 1'b1;
      end
      OP_JALR: begin
        dec.imm_src   = IMM_I;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.wb_src    = WB_PC4;
        dec.is_jump   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        dec.imm_src   = IMM_U;
        dec.reg_write = 1'b1;
        dec.wb_src    = WB_U;
        dec.u_src     = (id_opcode_i == OP_LUI);
      end
      default: dec.illegal = 1'b1;
    endcase
    // rd only matters when something is written back
    dec.rd = dec.reg_write ? id_rd_i : '0;
  end

  always_comb begin
    rs1_used = !((id_opcode_i == OP_LUI) || (id_opcode_i == OP_AUIPC) || (id_opcode_i == OP_JAL));
    rs2_used = (id_opcode_i == OP_R) || (id_opcode_i == OP_STORE) || (id_opcode_i == OP_BRANCH);
  end

  always_comb begin
    case (ex_q.func3)
      3'b000:         taken = ex_alu_zero_i;
      3'b001:         taken = !ex_alu_zero_i;
      3'b100, 3'b110: taken = ex_alu_lsb_i;
      3'b101, 3'b111: taken = !ex_alu_lsb_i;
      default:        taken = 1'b0;
    endcase
  end

  assign busy  = (cnt_q != 8'd0);
  assign flush = ex_q.valid & ((ex_q.is_branch & taken) | ex_q.is_jump);
  assign lu    = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & id_valid_i &
                 ((rs1_used & (id_rs1_i == ex_q.rd)) | (rs2_used & (id_rs2_i == ex_q.rd)));

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (busy) begin
      cnt_d = cnt_q - 8'd1;
    end else if (flush || lu || !id_valid_i) begin
      ex_d = bub;
    end else begin
      ex_d = dec;
      if (dec_is_m) cnt_d = id_func3_i[2] ? DIV_LD : MUL_LD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q         <= '0;
      ex_q.imm_src <= IMM_NONE;
      cnt_q        <= 8'd0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_o        = lu | busy;
  assign flush_o        = flush;
  assign ex_valid_o     = ex_q.valid;
  assign ex_imm_src_o   = ex_q.imm_src;
  assign ex_mem_read_o  = ex_q.mem_read;
  assign ex_mem_write_o = ex_q.mem_write;
  assign ex_alu_src_o   = ex_q.alu_src;
  assign ex_reg_write_o = ex_q.reg_write;
  assign ex_wb_src_o    = ex_q.wb_src;
  assign ex_u_src_o     = ex_q.u_src;
  assign ex_alu_ctrl_o  = ex_q.alu_ctrl;
  assign ex_rd_o        = ex_q.rd;
  assign ex_illegal_o   = ex_q.illegal;
  assign ex_mdu_busy_o  = busy;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: decode table, hazard/flush/MDU sequences and a
// randomized run against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011, ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;

  logic clk = 1'b0, rst;
  logic id_valid, zero, lsb;
  logic [6:0] id_op, id_f7;
  logic [2:0] id_f3;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic stall, flush, ex_valid, ex_mr, ex_mw, ex_as, ex_rw, ex_us, ex_ill, ex_busy;
  logic [2:0] ex_imm;
  logic [1:0] ex_wb;
  logic [4:0] ex_alu, ex_rd;
  logic s_stall, s_flush, s_valid, s_mr, s_mw, s_as, s_rw, s_us, s_ill, s_busy;
  logic [2:0] s_imm;
  logic [1:0] s_wb;
  logic [4:0] s_alu, s_rd;

  int n_chk = 0, n_fail = 0;

  pipe_ctrl_unit #(.REG_ADDR_W(5), .EN_M_EXT(1), .MUL_LATENCY(3), .DIV_LATENCY(32)) u_dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_opcode_i(id_op), .id_func3_i(id_f3),
    .id_func7_i(id_f7), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .ex_alu_zero_i(zero), .ex_alu_lsb_i(lsb), .stall_o(stall), .flush_o(flush),
    .ex_valid_o(ex_valid), .ex_imm_src_o(ex_imm), .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw),
    .ex_alu_src_o(ex_as), .ex_reg_write_o(ex_rw), .ex_wb_src_o(ex_wb), .ex_u_src_o(ex_us),
    .ex_alu_ctrl_o(ex_alu), .ex_rd_o(ex_rd), .ex_illegal_o(ex_ill), .ex_mdu_busy_o(ex_busy));

  // single-cycle MDU variant, used only for the zero-stall multiply case
  pipe_ctrl_unit #(.REG_ADDR_W(5), .EN_M_EXT(1), .MUL_LATENCY(1), .DIV_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid_i(id_valid), .id_opcode_i(id_op), .id_func3_i(id_f3),
    .id_func7_i(id_f7), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .ex_alu_zero_i(zero), .ex_alu_lsb_i(lsb), .stall_o(s_stall), .flush_o(s_flush),
    .ex_valid_o(s_valid), .ex_imm_src_o(s_imm), .ex_mem_read_o(s_mr), .ex_mem_write_o(s_mw),
    .ex_alu_src_o(s_as), .ex_reg_write_o(s_rw), .ex_wb_src_o(s_wb), .ex_u_src_o(s_us),
    .ex_alu_ctrl_o(s_alu), .ex_rd_o(s_rd), .ex_illegal_o(s_ill), .ex_mdu_busy_o(s_busy));

  always #5 clk = ~clk;

  typedef struct {
    logic valid; logic [2:0] imm; logic mr, mw, as, rw; logic [1:0] wb; logic us;
    logic [4:0] alu; logic [4:0] rd; logic ill; logic br, jmp, is_m; logic [2:0] f3;
  } ref_t;

  typedef struct {
    string nm; logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [2:0] imm; logic as, rw, mr, mw; logic [1:0] wb; logic us; logic [4:0] alu; logic ill;
  } vec_t;

  logic [31:0] act_b;
  assign act_b = {10'd0, ex_valid, ex_imm, ex_mr, ex_mw, ex_as, ex_rw, ex_wb, ex_us, ex_alu, ex_rd, ex_ill};

  function automatic logic [31:0] pk(input ref_t r);
    pk = {10'd0, r.valid, r.imm, r.mr, r.mw, r.as, r.rw, r.wb, r.us, r.alu, r.rd, r.ill};
  endfunction

  function automatic ref_t bubble();
    ref_t r;
    r = '{valid: 0, imm: 3'b111, mr: 0, mw: 0, as: 0, rw: 0, wb: 0, us: 0, alu: 0, rd: 0,
          ill: 0, br: 0, jmp: 0, is_m: 0, f3: 0};
    return r;
  endfunction

  // instruction-level reference decode: base ALU op by func3 lookup, +1 for the alternate form
  function automatic ref_t ref_dec(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [6:0] f7, input logic [4:0] rd);
    ref_t r;
    logic [4:0] tab [8];
    logic ok;
    tab = '{5'd0, 5'd7, 5'd5, 5'd6, 5'd4, 5'd8, 5'd3, 5'd2};
    r = bubble();
    r.valid = 1;
    case (op)
      R: begin
        r.rw = 1;
        if (f7 == 7'b0000001) begin r.is_m = 1; r.alu = {2'b10, f3}; end
        else r.alu = tab[f3] + 5'((f7[5] && (f3 == 0 || f3 == 5)) ? 1 : 0);
      end
      I: begin
        r.imm = 0; r.as = 1;
        ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
        r.rw = ok;
        r.alu = ok ? tab[f3] + 5'((f3 == 5 && f7[5]) ? 1 : 0) : 5'd0;
      end
      LD:  begin r.imm = 0; r.as = 1; r.rw = 1; r.mr = 1; r.wb = 1; end
      ST:  begin r.imm = 1; r.as = 1; r.mw = 1; end
      BR:  begin
        r.imm = 2; r.br = 1; r.f3 = f3;
        r.alu = !f3[2] ? (f3[1] ? 5'd0 : 5'd1) : (f3[1] ? 5'd6 : 5'd5);
      end
      JAL:   begin r.imm = 3; r.rw = 1; r.wb = 2; r.jmp = 1; end
      JALR:  begin r.imm = 0; r.as = 1; r.rw = 1; r.wb = 2; r.jmp = 1; end
      LUI:   begin r.imm = 4; r.rw = 1; r.wb = 3; r.us = 1; end
      AUIPC: begin r.imm = 4; r.rw = 1; r.wb = 3; end
      default: r.ill = 1;
    endcase
    r.rd = r.rw ? rd : 5'd0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    id_valid = v; id_op = op; id_f3 = f3; id_f7 = f7; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
  endtask

  task automatic tick();   @(posedge clk); #1; endtask
  task automatic settle(); #2; endtask

  task automatic reset_all();
    rst = 1; drive(0, 0, 0, 0, 0, 0, 0); zero = 0; lsb = 0;
    @(posedge clk); #1; rst = 0;
  endtask

  vec_t vt [18];
  ref_t m, e;
  int   left, nst, k, sel;
  logic hold, e_lu, e_flush, e_stall, e_take, u1, u2;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{"addi",  I, 0, 7'h00, 0, 1, 1, 0, 0, 0, 0, 5'd0, 0};
    vt[1]  = '{"slli",  I, 1, 7'h00, 0, 1, 1, 0, 0, 0, 0, 5'd7, 0};
    vt[2]  = '{"slli_bad", I, 1, 7'h20, 0, 1, 0, 0, 0, 0, 0, 5'd0, 0};
    vt[3]  = '{"srai",  I, 5, 7'h20, 0, 1, 1, 0, 0, 0, 0, 5'd9, 0};
    vt[4]  = '{"add",   R, 0, 7'h00, 7, 0, 1, 0, 0, 0, 0, 5'd0, 0};
    vt[5]  = '{"sub",   R, 0, 7'h20, 7, 0, 1, 0, 0, 0, 0, 5'd1, 0};
    vt[6]  = '{"sltu",  R, 3, 7'h00, 7, 0, 1, 0, 0, 0, 0, 5'd6, 0};
    vt[7]  = '{"lw",    LD, 2, 7'h00, 0, 1, 1, 1, 0, 1, 0, 5'd0, 0};
    vt[8]  = '{"sw",    ST, 2, 7'h00, 1, 1, 0, 0, 1, 0, 0, 5'd0, 0};
    vt[9]  = '{"beq",   BR, 0, 7'h00, 2, 0, 0, 0, 0, 0, 0, 5'd1, 0};
    vt[10] = '{"bltu",  BR, 6, 7'h00, 2, 0, 0, 0, 0, 0, 0, 5'd6, 0};
    vt[11] = '{"jal",   JAL, 0, 7'h00, 3, 0, 1, 0, 0, 2, 0, 5'd0, 0};
    vt[12] = '{"jalr",  JALR, 0, 7'h00, 0, 1, 1, 0, 0, 2, 0, 5'd0, 0};
    vt[13] = '{"lui",   LUI, 0, 7'h00, 4, 0, 1, 0, 0, 3, 1, 5'd0, 0};
    vt[14] = '{"auipc", AUIPC, 0, 7'h00, 4, 0, 1, 0, 0, 3, 0, 5'd0, 0};
    vt[15] = '{"illegal", 7'h7F, 0, 7'h00, 7, 0, 0, 0, 0, 0, 0, 5'd0, 1};
    vt[16] = '{"div",   R, 4, 7'h01, 7, 0, 1, 0, 0, 0, 0, 5'b10100, 0};
    vt[17] = '{"mul",   R, 0, 7'h01, 7, 0, 1, 0, 0, 0, 0, 5'b10000, 0};

    // reset state, then addi x1 for three clocks
    rst = 1; drive(0, 0, 0, 0, 0, 0, 0); zero = 0; lsb = 0;
    #3;
    chk("rst_ex_valid", ex_valid, 0); chk("rst_imm", ex_imm, 3'b111);
    chk("rst_stall", stall, 0); chk("rst_flush", flush, 0); chk("rst_busy", ex_busy, 0);
    tick(); tick(); rst = 0;
    drive(1, I, 0, 0, 0, 0, 1);
    tick(); tick(); tick(); settle();
    chk("addi_alu_src", ex_as, 1); chk("addi_reg_write", ex_rw, 1); chk("addi_imm", ex_imm, 0);

    // decode table, one instruction at a time between bubbles
    for (int i = 0; i < 18; i++) begin
      reset_all();
      drive(1, vt[i].op, vt[i].f3, vt[i].f7, 0, 0, 1);
      tick(); drive(0, 0, 0, 0, 0, 0, 0); settle();
      e = bubble();
      e.valid = 1; e.imm = vt[i].imm; e.as = vt[i].as; e.rw = vt[i].rw; e.mr = vt[i].mr;
      e.mw = vt[i].mw; e.wb = vt[i].wb; e.us = vt[i].us; e.alu = vt[i].alu; e.ill = vt[i].ill;
      e.rd = vt[i].rw ? 5'd1 : 5'd0;
      chk({"tab_", vt[i].nm}, act_b, pk(e));
      nst = 0;
      while (stall && nst < 64) begin tick(); settle(); nst++; end
      chk({"tab_drain_", vt[i].nm}, stall, 0);
    end

    // load-use: lw x5 ; add x6,x5,x7
    reset_all();
    drive(1, LD, 2, 0, 0, 0, 5); tick();
    drive(1, R, 0, 0, 5, 7, 6); settle();
    chk("lu_stall", stall, 1);
    tick(); settle();
    chk("lu_bubble", ex_valid, 0); chk("lu_stall_once", stall, 0);
    tick(); settle();
    chk("lu_add_rd", {ex_valid, ex_rd}, {1'b1, 5'd6});
    drive(1, LD, 2, 0, 0, 0, 0); tick();
    drive(1, R, 0, 0, 0, 0, 6); settle();
    chk("lu_x0_nostall", stall, 0);

    // branch / jump resolution
    reset_all();
    drive(1, BR, 0, 0, 1, 2, 0); tick();
    drive(1, I, 0, 0, 0, 0, 3); zero = 1; settle();
    chk("beq_flush", flush, 1); chk("beq_nostall", stall, 0);
    tick(); settle();
    chk("beq_bubble", ex_valid, 0);
    drive(1, BR, 1, 0, 1, 2, 0); tick();
    drive(1, I, 0, 0, 0, 0, 3); zero = 1; settle();
    chk("bne_noflush", flush, 0);
    tick(); drive(1, JAL, 0, 0, 0, 0, 1); tick();
    drive(1, I, 0, 0, 0, 0, 3); zero = 0; lsb = 0; settle();
    chk("jal_flush_a", flush, 1);
    zero = 1; lsb = 1; #1;
    chk("jal_flush_b", flush, 1);

    // divide occupies EX for 32 cycles
    reset_all();
    drive(1, R, 4, 7'h01, 1, 2, 4); tick();
    drive(1, R, 0, 0, 1, 2, 9); settle();
    chk("div_alu", ex_alu, 5'b10100);
    nst = 0;
    while (stall && nst < 100) begin nst++; tick(); settle(); end
    chk("div_stall_cycles", nst, 31);
    tick(); settle();
    chk("div_next_enters", {ex_valid, ex_rd}, {1'b1, 5'd9});

    // single-cycle multiply never stalls
    reset_all();
    drive(1, R, 0, 7'h01, 1, 2, 4); tick();
    drive(1, R, 0, 0, 1, 2, 9); settle();
    chk("mul1_stall", s_stall, 0); chk("mul1_busy", s_busy, 0); chk("mul3_stall", stall, 1);
    tick(); settle();
    chk("mul1_next", {s_valid, s_rd}, {1'b1, 5'd9});

    // reset in the middle of a divide
    reset_all();
    drive(1, R, 4, 7'h01, 1, 2, 4); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 21; i++) tick();
    settle();
    chk("midrst_busy_before", ex_busy, 1);
    rst = 1; #1;
    chk("midrst_busy", ex_busy, 0); chk("midrst_stall", stall, 0); chk("midrst_valid", ex_valid, 0);
    #1; rst = 0;
    drive(1, R, 0, 0, 1, 2, 9);
    tick(); settle();
    chk("midrst_add", {ex_valid, ex_rw, ex_rd}, {1'b1, 1'b1, 5'd9});

    // randomized run against the pipeline model
    reset_all();
    m = bubble(); left = 0; hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (!hold) begin
        k = $urandom_range(0, 10);
        case (k)
          0: id_op = R; 1: id_op = I; 2: id_op = LD; 3: id_op = ST; 4: id_op = BR;
          5: id_op = JAL; 6: id_op = JALR; 7: id_op = LUI; 8: id_op = AUIPC;
          default: id_op = 7'($urandom);
        endcase
        sel = $urandom_range(0, 7);
        id_f7 = (sel < 4) ? 7'h00 : (sel < 6) ? 7'h20 : (sel == 6) ? 7'h01 : 7'($urandom);
        id_f3 = 3'($urandom);
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        id_rd = 5'($urandom_range(0, 3));
        id_valid = ($urandom_range(0, 9) != 0);
      end
      zero = 1'($urandom); lsb = 1'($urandom);
      settle();
      u1 = !(id_op == LUI || id_op == AUIPC || id_op == JAL);
      u2 = (id_op == R || id_op == ST || id_op == BR);
      e_lu = m.valid && m.mr && m.rd != 0 && id_valid &&
             ((u1 && id_rs1 == m.rd) || (u2 && id_rs2 == m.rd));
      e_take = m.br && ((m.f3 == 0 && zero) || (m.f3 == 1 && !zero) ||
               ((m.f3 == 4 || m.f3 == 6) && lsb) || ((m.f3 == 5 || m.f3 == 7) && !lsb));
      e_flush = m.valid && (e_take || m.jmp);
      e_stall = e_lu || (left > 0);
      chk("rnd_stall", stall, e_stall);
      chk("rnd_flush", flush, e_flush);
      chk("rnd_busy", ex_busy, left > 0);
      chk("rnd_ex", act_b, pk(m));
      if (left > 0) left--;
      else if (e_flush || e_lu || !id_valid) m = bubble();
      else begin
        m = ref_dec(id_op, id_f3, id_f7, id_rd);
        if (m.is_m) left = (id_f3[2] ? 32 : 3) - 1;
      end
      hold = e_stall;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
